// File: rtl/arm_exec_datapath.sv
// Execute-stage slice: barrel shifter on operand B, 32-bit ALU with registered
// result/NZCV, and the address register with its incrementer bus.
module arm_exec_datapath #(
    parameter int WIDTH    = 32,
    parameter int ADDR_INC = 4,
    localparam int SW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       shift_mode,
    input  logic [SW-1:0]    shift_count,
    input  logic             carry_in,
    input  logic             invert_a,
    input  logic             invert_b,
    input  logic             is_logic,
    input  logic [2:0]       logic_idx,
    input  logic             alu_cin,
    input  logic             alu_active,
    output logic [WIDTH-1:0] shifter_out,
    output logic             shifter_carry,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_valid,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    input  logic [WIDTH-1:0] addr_in,
    input  logic             ale,
    input  logic             addr_inc,
    input  logic             abe,
    output logic [WIDTH-1:0] addr_out,
    output logic [WIDTH-1:0] incr_out
);
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_a, w_bx, w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c, w_v;
    logic [WIDTH-1:0] r_ar;

    // Shifts run on a 33-bit extension so the carry falls out as the spare bit.
    always_comb begin
        shifter_out   = op_b;
        shifter_carry = carry_in;
        w_ext         = '0;
        case (shift_mode)
            3'd0: if (shift_count != '0) begin
                w_ext         = {1'b0, op_b} << shift_count;
                shifter_out   = w_ext[WIDTH-1:0];
                shifter_carry = w_ext[WIDTH];
            end
            3'd1: if (shift_count != '0) begin
                w_ext         = {op_b, 1'b0} >> shift_count;
                shifter_out   = w_ext[WIDTH:1];
                shifter_carry = w_ext[0];
            end
            3'd2: if (shift_count != '0) begin
                w_ext         = $unsigned($signed({op_b, 1'b0}) >>> shift_count);
                shifter_out   = w_ext[WIDTH:1];
                shifter_carry = w_ext[0];
            end
            3'd3: if (shift_count != '0) begin
                shifter_out   = (op_b >> shift_count) | (op_b << (WIDTH - int'(shift_count)));
                shifter_carry = shifter_out[WIDTH-1];
            end
            3'd4: begin
                shifter_out   = {carry_in, op_b[WIDTH-1:1]};
                shifter_carry = op_b[0];
            end
            default: ;
        endcase
    end

    assign w_a   = invert_a ? ~op_a : op_a;
    assign w_bx  = invert_b ? ~shifter_out : shifter_out;
    assign w_sum = {1'b0, w_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, alu_cin};

    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
        if (is_logic) begin
            w_c = shifter_carry;
            w_v = flag_v;
            case (logic_idx)
                3'd0:    w_res = w_a & w_bx;
                3'd1:    w_res = w_a | w_bx;
                3'd2:    w_res = w_a ^ w_bx;
                3'd3:    w_res = w_bx;
                default: w_res = w_a;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            alu_valid  <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
        end else begin
            alu_valid <= alu_active;
            if (alu_active) begin
                alu_result <= w_res;
                flag_n     <= w_res[WIDTH-1];
                flag_z     <= (w_res == '0);
                flag_c     <= w_c;
                flag_v     <= w_v;
            end
        end
    end

    // Load wins over increment; increment wraps naturally modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_ar <= '0;
        else if (ale)      r_ar <= addr_in;
        else if (addr_inc) r_ar <= incr_out;
    end

    assign incr_out = r_ar + WIDTH'(ADDR_INC);
    assign addr_out = abe ? r_ar : '0;
endmodule

// File: tb/tb_arm_exec_datapath.sv
// Randomized + directed bench for arm_exec_datapath against an arithmetic reference model.
module tb_arm_exec_datapath;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, addr_in = '0;
    logic [2:0]  shift_mode = '0, logic_idx = '0;
    logic [4:0]  shift_count = '0;
    logic        carry_in = 0, invert_a = 0, invert_b = 0, is_logic = 0, alu_cin = 0, alu_active = 0;
    logic        ale = 0, addr_inc = 0, abe = 0;
    logic [31:0] shifter_out, alu_result, addr_out, incr_out;
    logic        shifter_carry, alu_valid, flag_n, flag_z, flag_c, flag_v;

    int n_checks = 0, n_err = 0;
    logic [31:0] m_res = '0, m_ar = '0;
    logic [3:0]  m_nzcv = '0;

    arm_exec_datapath dut (
        .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .shift_mode(shift_mode),
        .shift_count(shift_count), .carry_in(carry_in), .invert_a(invert_a), .invert_b(invert_b),
        .is_logic(is_logic), .logic_idx(logic_idx), .alu_cin(alu_cin), .alu_active(alu_active),
        .shifter_out(shifter_out), .shifter_carry(shifter_carry), .alu_result(alu_result),
        .alu_valid(alu_valid), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .addr_in(addr_in), .ale(ale), .addr_inc(addr_inc), .abe(abe),
        .addr_out(addr_out), .incr_out(incr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_shift(input logic [31:0] b, input logic [2:0] m,
                                              input int k, input logic ci);
        longint unsigned x = 64'(b);
        longint s = longint'($signed(b));
        logic [31:0] o = b;
        logic co = ci;
        if (m == 3'd4) begin
            o = {ci, b[31:1]};
            co = b[0];
        end else if (m < 3'd4 && k != 0) begin
            case (m)
                3'd0: begin o = 32'(x << k); co = 1'(x >> (32 - k)); end
                3'd1: begin o = 32'(x >> k); co = 1'(x >> (k - 1)); end
                3'd2: begin o = 32'(s >>> k); co = 1'(s >>> (k - 1)); end
                default: begin o = 32'((x >> k) | (x << (32 - k))); co = o[31]; end
            endcase
        end
        return {co, o};
    endfunction

    // Drives one ALU op with alu_active high and checks shifter + registered outputs.
    task automatic do_alu(input logic [31:0] a, b, input logic [2:0] m, input logic [4:0] n,
                          input logic ci, ia, ib, il, input logic [2:0] li, input logic acin);
        logic [32:0] sh;
        logic [31:0] av, bx, r;
        longint unsigned sum;
        logic c, v;
        op_a = a; op_b = b; shift_mode = m; shift_count = n; carry_in = ci;
        invert_a = ia; invert_b = ib; is_logic = il; logic_idx = li; alu_cin = acin;
        alu_active = 1;
        sh = ref_shift(b, m, int'(n), ci);
        av = ia ? ~a : a;
        bx = ib ? ~sh[31:0] : sh[31:0];
        if (!il) begin
            sum = 64'(av) + 64'(bx) + 64'(acin);
            r = 32'(sum);
            c = sum[32];
            v = (av[31] == bx[31]) && (r[31] != av[31]);
        end else begin
            case (li)
                3'd0: r = av & bx;
                3'd1: r = av | bx;
                3'd2: r = av ^ bx;
                3'd3: r = bx;
                default: r = av;
            endcase
            c = sh[32];
            v = m_nzcv[0];
        end
        #1;
        chk("shifter_out", shifter_out, sh[31:0]);
        chk("shifter_carry", 32'(shifter_carry), 32'(sh[32]));
        @(posedge clk); #1;
        m_res = r;
        m_nzcv = {r[31], r == 32'd0, c, v};
        chk("alu_result", alu_result, m_res);
        chk("nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(m_nzcv));
        chk("alu_valid_hi", 32'(alu_valid), 32'd1);
    endtask

    task automatic idle(input int cycles);
        alu_active = 0;
        op_a = $urandom; op_b = $urandom;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk("alu_valid_lo", 32'(alu_valid), 32'd0);
            chk("hold_result", alu_result, m_res);
            chk("hold_nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(m_nzcv));
        end
    endtask

    task automatic do_addr(input logic l, inc, en, input logic [31:0] ain);
        ale = l; addr_inc = inc; abe = en; addr_in = ain;
        @(posedge clk); #1;
        if (l) m_ar = ain;
        else if (inc) m_ar = m_ar + 32'd4;
        chk("addr_out", addr_out, en ? m_ar : 32'd0);
        chk("incr_out", incr_out, m_ar + 32'd4);
        ale = 0; addr_inc = 0;
    endtask

    initial begin
        #3;
        chk("rst_result", alu_result, 32'd0);
        chk("rst_nzcv_valid", 32'({flag_n, flag_z, flag_c, flag_v, alu_valid}), 32'd0);
        abe = 1; #1;
        chk("rst_ar", addr_out, 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        do_alu(32'd5, 32'h0F, 3'd0, 5'd0, 0, 0, 0, 0, 3'd0, 0);
        chk("tp_add", alu_result, 32'h14);
        chk("tp_add_nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
        idle(1);
        do_alu(32'd0, 32'h0F, 3'd3, 5'd4, 0, 0, 0, 1, 3'd3, 0);
        chk("tp_ror", shifter_out, 32'hF000_0000);
        chk("tp_ror_c", 32'(shifter_carry), 32'd1);
        do_alu(32'd3, 32'd5, 3'd0, 5'd0, 0, 0, 1, 0, 3'd0, 1);
        chk("tp_sub", alu_result, 32'hFFFF_FFFE);
        chk("tp_sub_nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'b1000);
        do_alu(32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 0, 0, 0, 0, 3'd0, 0);
        chk("tp_ovf", 32'({flag_n, flag_z, flag_c, flag_v}), 32'b1001);
        do_alu(32'hFFFF_FFFF, 32'd1, 3'd0, 5'd0, 0, 0, 0, 0, 3'd0, 0);
        chk("tp_zero", 32'({alu_result == 0, flag_z, flag_c, flag_v}), 32'b1110);
        do_alu(32'd5, 32'd3, 3'd0, 5'd0, 1, 0, 0, 1, 3'd0, 0);
        chk("tp_and", 32'({alu_result[3:0], flag_c, flag_v}), 32'b0001_10);
        do_alu(32'd0, 32'h8000_0000, 3'd2, 5'd4, 0, 0, 0, 1, 3'd1, 0);
        chk("tp_asr", shifter_out, 32'hF800_0000);
        do_alu(32'd0, 32'd1, 3'd4, 5'd7, 1, 0, 0, 1, 3'd3, 0);
        chk("tp_rrx", 32'({shifter_carry, shifter_out[31:1]}), 32'hC000_0000);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            do_alu($urandom, $urandom, 3'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
            if ($urandom_range(3) == 0) idle(1);
        end
        idle(1);

        do_addr(1, 0, 1, 32'hFFFF_FFFC);
        chk("tp_ar_fffc", incr_out, 32'd0);
        do_addr(0, 1, 1, 32'h0);
        chk("tp_ar_wrap", addr_out, 32'd0);
        do_addr(1, 1, 1, 32'h100);
        chk("tp_ar_pri", addr_out, 32'h100);
        do_addr(0, 0, 0, 32'h55);
        for (int i = 0; i < 20; i++)
            do_addr(1'($urandom_range(3) == 0), 1'($urandom), 1'($urandom), $urandom);

        do_addr(1, 0, 1, 32'h1234_5678);
        do_alu(32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 0, 0, 0, 0, 3'd0, 0);
        #2 rst_n = 0; #1;
        m_res = '0; m_nzcv = '0; m_ar = '0;
        chk("mid_rst_result", alu_result, 32'd0);
        chk("mid_rst_flags", 32'({flag_n, flag_z, flag_c, flag_v, alu_valid}), 32'd0);
        chk("mid_rst_ar", addr_out, 32'd0);
        alu_active = 0;
        @(negedge clk); rst_n = 1;
        idle(3);
        do_addr(0, 1, 1, 32'h0);
        chk("post_rst_inc", addr_out, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/arm_exec_datapath.md
Name: arm_exec_datapath

Overview:
- Execute-stage datapath slice: barrel shifter feeding operand B of a 32-bit ALU, plus the address register with its +4 incrementer.
- Sits between the register-read stage (operands busA/busB) and the write-back and memory stages.
- Shifter is combinational; ALU result and flags are registered. The address register is clocked.

Parameters:
- WIDTH, 32, datapath width; shift count width is log2(WIDTH).
- ADDR_INC, 4, incrementer step in bytes.

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- op_a in 32: busA, ALU operand A.
- op_b in 32: busB, shifter input.
- shift_mode in 3: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 pass.
- shift_count in 5: shift amount.
- carry_in in 1: current CPSR C flag.
- invert_a in 1: use ~A.
- invert_b in 1: use ~B'.
- is_logic in 1: 1 selects logic op, 0 selects add.
- logic_idx in 3: logic op select.
- alu_cin in 1: adder carry in.
- alu_active in 1: execute strobe.
- shifter_out out 32: combinational shifter result B'.
- shifter_carry out 1: combinational shifter carry-out.
- alu_result out 32: registered ALU result.
- alu_valid out 1: one-cycle pulse, result updated.
- flag_n, flag_z, flag_c, flag_v out 1 each: registered flags.
- addr_in in 32: alubus, address load value.
- ale in 1: address latch enable.
- addr_inc in 1: advance address register by ADDR_INC.
- abe in 1: address bus enable.
- addr_out out 32: ar when abe=1, else 0.
- incr_out out 32: combinational ar + ADDR_INC (incrementer bus).

Behaviour:
- Reset (async, rst_n=0): alu_result, all flags, alu_valid and the address register clear to 0.
- Shifter (combinational), with n = shift_count:
  - LSL: B'=B<<n; carry = B[32-n].
  - LSR: B'=B>>n; carry = B[n-1].
  - ASR: arithmetic right shift; carry = B[n-1].
  - ROR: rotate right n; carry = B'[31].
  - n=0 in modes 0-3: B'=B, carry=carry_in.
  - RRX: B'={carry_in,B[31:1]}, carry=B[0]; shift_count ignored.
  - Modes 5-7: B'=B, carry=carry_in.
- ALU operands: A'=invert_a?~op_a:op_a; Bx=invert_b?~B':B'.
- Arithmetic (is_logic=0):
  - sum = A'+Bx+alu_cin, 33-bit.
  - C = bit 32.
  - V = (A'[31]==Bx[31]) && (sum[31]!=A'[31]).
  - SUB is invert_b=1, cin=1; RSB is invert_a=1, cin=1.
- Logic (is_logic=1), by logic_idx: 0 AND, 1 OR, 2 XOR, 3 pass Bx, 4-7 pass A'.
  - C = shifter_carry; V holds its previous value.
- N = result[31]; Z = (result==0).
- Latency: on a rising clk with alu_active=1, alu_result and all flags load together and alu_valid=1 for the following cycle.
- With alu_active=0: result and flags hold, alu_valid=0.
- Back-to-back alu_active gives one result per cycle.
- Address register, per rising edge:
  - ale=1: ar <= addr_in.
  - else addr_inc=1: ar <= ar+ADDR_INC, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - else: hold.
  - ale has priority when both are asserted.
- incr_out is always ar+ADDR_INC.
- Reset asserted mid-operation clears state immediately. The first edge after rst_n release behaves normally.

Test Plan:
- Add: op_a=5, op_b=0x0F, LSL #0, arithmetic, cin=0, alu_active pulse -> alu_result=0x00000014, NZCV=0000, alu_valid one-cycle pulse.
- Immediate rotate plus SUB:
  - op_b=0x0F, ROR #4 -> shifter_out=0xF0000000, shifter_carry=1.
  - SUB op_a=3, op_b=5, LSL #0 -> result=0xFFFFFFFE, N=1 Z=0 C=0 V=0.
- Overflow and zero:
  - 0x7FFFFFFF+1 -> 0x80000000, N=1 V=1 C=0.
  - 0xFFFFFFFF+1 -> 0, Z=1 C=1 V=0.
- Logic:
  - AND 5 & 3 with LSL #0, carry_in=1 -> result=1, C=1, V unchanged.
  - ASR op_b=0x80000000 #4 -> shifter_out=0xF8000000.
  - RRX op_b=1, carry_in=1 -> shifter_out=0x80000000, carry=1.
- Address register:
  - ale with addr_in=0xFFFFFFFC -> ar=0xFFFFFFFC, incr_out=0.
  - addr_inc -> ar=0.
  - ale and addr_inc together with addr_in=0x100 -> ar=0x100.
  - abe=0 -> addr_out=0.
- Reset: assert rst_n=0 mid-cycle after nonzero results -> result, flags, alu_valid and ar read 0 immediately; hold with alu_active=0 keeps values stable over 3 cycles.
